pipe_run_ctrl: RTL

Synthesizable run controller that drives a clock-enable into the pipeline core, which replaces hand-toggled clock sequences. It counts executed core cycles and stops the core on a programmable cycle budget, a core halt request, or an external stop. It supports free-run and single-step modes and a programmable enable divider. It sits between the board or bench clock and the pipeline's enable input.

---
 rtl/pipe_run_ctrl_if.sv | 35 +++
 rtl/pipe_run_ctrl.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/pipe_run_ctrl_if.sv
// pipe_run_ctrl_if -- handshake/bus bundle between a run-control master
// (board logic or bench) and the pipe_run_ctrl block.
//
// Parameters: CNT_W (cycle counter / budget width), DIV_W (divider width).
// Signals:
//   start, step, stop, budget, div, halt_req, heartbeat  master -> controller
//   cpu_en, cycle_count, state, done, timeout, wdog_fired controller -> master
interface pipe_run_ctrl_if #(
   parameter int unsigned CNT_W = 32,
   parameter int unsigned DIV_W = 4
);
   logic             start;
   logic             step;
   logic             stop;
   logic [CNT_W-1:0] budget;
   logic [DIV_W-1:0] div;
   logic             halt_req;
   logic             heartbeat;
   logic             cpu_en;
   logic [CNT_W-1:0] cycle_count;
   logic [1:0]       state;
   logic             done;
   logic             timeout;
   logic             wdog_fired;

   modport master (
      output start, step, stop, budget, div, halt_req, heartbeat,
      input  cpu_en, cycle_count, state, done, timeout, wdog_fired
   );

   modport slave (
      input  start, step, stop, budget, div, halt_req, heartbeat,
      output cpu_en, cycle_count, state, done, timeout, wdog_fired
   );
endinterface

// File: rtl/pipe_run_ctrl.sv
// pipe_run_ctrl -- run controller producing a registered clock-enable for a
// pipeline core. Supports free-run and single-step, a programmable enable
// divider, a cycle budget, core halt requests and an external stop.
//
// Ports:
//   clk  system clock, rising edge
//   rst  asynchronous active-high reset
//   bus  pipe_run_ctrl_if.slave: start/step/stop/budget/div/halt_req/heartbeat
//        in; cpu_en/cycle_count/state/done/timeout/wdog_fired out
//
// Build option: define PIPE_RUN_WATCHDOG_EN to add the heartbeat watchdog.
// Without it, heartbeat is ignored and wdog_fired is constant 0.
module pipe_run_ctrl #(
   parameter int unsigned CNT_W      = 32,
   parameter int unsigned DIV_W      = 4,
   parameter int unsigned WDOG_LIMIT = 64
) (
   input  logic           clk,
   input  logic           rst,
   pipe_run_ctrl_if.slave bus
);

   if (WDOG_LIMIT < 1) begin : g_bad_wdog_limit
      $error("pipe_run_ctrl: WDOG_LIMIT must be at least 1");
   end

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      STEP   = 2'd2,
      HALTED = 2'd3
   } state_t;

   state_t           cur_state, nxt_state;
   logic             cpu_en_r, nxt_en;
   logic [CNT_W-1:0] count_r, nxt_count;
   logic [CNT_W-1:0] budget_r, nxt_budget;
   logic [DIV_W-1:0] div_r, nxt_div;
   logic [DIV_W-1:0] div_cnt, nxt_div_cnt;
   logic             done_r, nxt_done;
   logic             timeout_r, nxt_timeout;
   logic             budget_hit;

`ifdef PIPE_RUN_WATCHDOG_EN
   localparam int unsigned WCNT_W = $clog2(WDOG_LIMIT + 1);
   logic [WCNT_W-1:0] wcnt, nxt_wcnt;
   logic              wdog_r, nxt_wdog;
`endif

   // Budget is checked against the registered count, so the final pulse is
   // visible for a full cycle and the stop happens on the following edge.
   assign budget_hit = (budget_r != '0) && (count_r == budget_r);

   always_comb begin
      nxt_state   = cur_state;
      nxt_en      = 1'b0;
      nxt_count   = count_r;
      nxt_budget  = budget_r;
      nxt_div     = div_r;
      nxt_div_cnt = div_cnt;
      nxt_done    = done_r;
      nxt_timeout = timeout_r;
`ifdef PIPE_RUN_WATCHDOG_EN
      nxt_wcnt    = wcnt;
      nxt_wdog    = wdog_r;
`endif
      case (cur_state)
         IDLE, HALTED: begin
            if (bus.stop) begin
               nxt_state = IDLE;
            end else if (bus.start || bus.step) begin
               nxt_state   = bus.start ? RUN : STEP;
               nxt_budget  = bus.budget;
               nxt_div     = bus.div;
               nxt_count   = '0;
               nxt_div_cnt = '0;
               nxt_done    = 1'b0;
               nxt_timeout = 1'b0;
`ifdef PIPE_RUN_WATCHDOG_EN
               nxt_wcnt    = '0;
               nxt_wdog    = 1'b0;
`endif
            end
         end
         default: begin
            if (bus.stop) begin
               nxt_state = IDLE;
            end else if (bus.halt_req) begin
               nxt_state = HALTED;
               nxt_done  = 1'b1;
            end else if (budget_hit) begin
               nxt_state   = HALTED;
               nxt_timeout = 1'b1;
`ifdef PIPE_RUN_WATCHDOG_EN
            end else if (wcnt >= WCNT_W'(WDOG_LIMIT)) begin
               nxt_state = HALTED;
               nxt_wdog  = 1'b1;
`endif
            end else if ((cur_state == STEP) && cpu_en_r) begin
               // The single step pulse was issued last edge.
               nxt_state = IDLE;
            end else if (div_cnt == div_r) begin
               nxt_div_cnt = '0;
               nxt_en      = 1'b1;
               if (count_r != '1) begin
                  nxt_count = count_r + CNT_W'(1);
               end
`ifdef PIPE_RUN_WATCHDOG_EN
               nxt_wcnt = wcnt + WCNT_W'(1);
`endif
            end else begin
               nxt_div_cnt = div_cnt + DIV_W'(1);
            end
         end
      endcase
`ifdef PIPE_RUN_WATCHDOG_EN
      if (bus.heartbeat) begin
         nxt_wcnt = '0;
      end
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cur_state <= IDLE;
         cpu_en_r  <= 1'b0;
         count_r   <= '0;
         budget_r  <= '0;
         div_r     <= '0;
         div_cnt   <= '0;
         done_r    <= 1'b0;
         timeout_r <= 1'b0;
      end else begin
         cur_state <= nxt_state;
         cpu_en_r  <= nxt_en;
         count_r   <= nxt_count;
         budget_r  <= nxt_budget;
         div_r     <= nxt_div;
         div_cnt   <= nxt_div_cnt;
         done_r    <= nxt_done;
         timeout_r <= nxt_timeout;
      end
   end

`ifdef PIPE_RUN_WATCHDOG_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wcnt   <= '0;
         wdog_r <= 1'b0;
      end else begin
         wcnt   <= nxt_wcnt;
         wdog_r <= nxt_wdog;
      end
   end

   assign bus.wdog_fired = wdog_r;
`else
   assign bus.wdog_fired = 1'b0;
`endif

   assign bus.cpu_en      = cpu_en_r;
   assign bus.cycle_count = count_r;
   assign bus.state       = cur_state;
   assign bus.done        = done_r;
   assign bus.timeout     = timeout_r;

endmodule
